// File: rtl/agc_reg_slice.sv
// agc_reg_slice: AGC central register slice (A/L/G/Q/Z, X/Y adder, carry-in latch) joined by a wired-OR read bus.
// Define AGC_EAC_EN for ones'-complement end-around carry; otherwise the adder wraps in two's complement.
module agc_reg_slice #(
  parameter int WIDTH = 16
) (
  input  logic             CLOCK,
  input  logic             rst_,
  input  logic [5:0]       RDG_,
  input  logic [5:0]       WRG_,
  input  logic             WYDG_,
  input  logic             A2XG_,
  input  logic             CLXC,
  input  logic             CI,
  input  logic             CGG,
  input  logic             SAG,
  input  logic [WIDTH-1:0] SA,
  output logic [WIDTH-1:0] WL,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             OVF
);
  logic [WIDTH-1:0] a_q, l_q, g_q, q_q, z_q, x_q, y_q;
  logic [WIDTH-1:0] a_d, l_d, g_d, q_d, z_d, x_d, y_d;
  logic             cir_q, cir_d, y_wr;
  logic [WIDTH:0]   s;

  always_comb begin
    s = {1'b0, x_q} + {1'b0, y_q} + {{WIDTH{1'b0}}, cir_q};
`ifdef AGC_EAC_EN
    SUM = s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, s[WIDTH]};
`else
    SUM = s[WIDTH-1:0];
`endif
    CO = s[WIDTH];
    OVF = SUM[WIDTH-1] ^ SUM[WIDTH-2];
    // All registers sit at zero during reset, so the bus is zero too
    WL = ({WIDTH{~RDG_[0]}} & a_q) | ({WIDTH{~RDG_[1]}} & l_q) |
         ({WIDTH{~RDG_[2]}} & g_q) | ({WIDTH{~RDG_[3]}} & q_q) |
         ({WIDTH{~RDG_[4]}} & z_q) | ({WIDTH{~RDG_[5]}} & SUM);
  end

  always_comb begin
    y_wr = ~WYDG_ | ~WRG_[5];
    a_d = WRG_[0] ? a_q : WL;
    l_d = WRG_[1] ? l_q : WL;
    q_d = WRG_[3] ? q_q : WL;
    z_d = WRG_[4] ? z_q : WL;
    g_d = CGG ? '0 : ~WRG_[2] ? WL : SAG ? SA : g_q;
    y_d = ~WYDG_ ? {WL[WIDTH-2:0], WL[WIDTH-1]} : ~WRG_[5] ? WL : y_q;
    x_d = CLXC ? '0 : ~A2XG_ ? a_q : y_wr ? '0 : x_q;
    cir_d = CI | (~y_wr & cir_q);
  end

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      a_q <= '0;
      l_q <= '0;
      g_q <= '0;
      q_q <= '0;
      z_q <= '0;
      x_q <= '0;
      y_q <= '0;
      cir_q <= 1'b0;
    end else begin
      a_q <= a_d;
      l_q <= l_d;
      g_q <= g_d;
      q_q <= q_d;
      z_q <= z_d;
      x_q <= x_d;
      y_q <= y_d;
      cir_q <= cir_d;
    end
  end

  assign G = g_q;
endmodule

// File: tb/tb_agc_reg_slice.sv
// tb_agc_reg_slice: directed vector table, reset-mid-operation sequence and randomized run against a reference model.
module tb_agc_reg_slice;
  logic        CLOCK = 1'b0;
  logic        rst_ = 1'b0;
  logic [5:0]  RDG_ = 6'h3F, WRG_ = 6'h3F;
  logic        WYDG_ = 1'b1, A2XG_ = 1'b1, CLXC = 1'b0, CI = 1'b0, CGG = 1'b0, SAG = 1'b0;
  logic [15:0] SA = 16'h0;
  logic [15:0] WL, G, SUM;
  logic        CO, OVF;

  agc_reg_slice #(.WIDTH(16)) dut (
    .CLOCK(CLOCK), .rst_(rst_), .RDG_(RDG_), .WRG_(WRG_), .WYDG_(WYDG_), .A2XG_(A2XG_),
    .CLXC(CLXC), .CI(CI), .CGG(CGG), .SAG(SAG), .SA(SA),
    .WL(WL), .G(G), .SUM(SUM), .CO(CO), .OVF(OVF)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  localparam logic [5:0] N = 6'h3F;
  localparam logic [5:0] RA = 6'h3E, RL = 6'h3D, RG = 6'h3B, RQ = 6'h37, RU = 6'h1F;
  localparam logic [5:0] WA = 6'h3E, WLG = 6'h3D, WG = 6'h3B, WQ = 6'h37, WY = 6'h1F;
`ifdef AGC_EAC_EN
  localparam logic [15:0] E = 16'h0002;
`else
  localparam logic [15:0] E = 16'h0001;
`endif

  typedef struct {
    logic [5:0]  rdg, wrg;
    logic        wydg, a2xg, clxc, ci, cgg, sag;
    logic [15:0] sa, wl, g, sum;
    logic        co, ovf;
  } vec_t;

  vec_t tbl[25];
  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] m_a, m_l, m_g, m_q, m_z, m_x, m_y;
  logic        m_cir;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    RDG_ = t.rdg; WRG_ = t.wrg; WYDG_ = t.wydg; A2XG_ = t.a2xg;
    CLXC = t.clxc; CI = t.ci; CGG = t.cgg; SAG = t.sag; SA = t.sa;
  endtask

  function automatic logic [16:0] m_raw();
    int unsigned t;
    t = int'(m_x) + int'(m_y) + int'(m_cir);
    return t[16:0];
  endfunction

  function automatic logic [15:0] m_sum();
    logic [16:0] r;
    r = m_raw();
`ifdef AGC_EAC_EN
    return r[15:0] + {15'b0, r[16]};
`else
    return r[15:0];
`endif
  endfunction

  function automatic logic [15:0] m_wl(input logic [5:0] r);
    logic [15:0] v;
    v = 16'h0;
    if (!r[0]) v |= m_a;
    if (!r[1]) v |= m_l;
    if (!r[2]) v |= m_g;
    if (!r[3]) v |= m_q;
    if (!r[4]) v |= m_z;
    if (!r[5]) v |= m_sum();
    return v;
  endfunction

  task automatic m_reset();
    m_a = 0; m_l = 0; m_g = 0; m_q = 0; m_z = 0; m_x = 0; m_y = 0; m_cir = 0;
  endtask

  task automatic m_step(input vec_t t);
    logic [15:0] wl, a_old;
    logic yw;
    wl = m_wl(t.rdg);
    a_old = m_a;
    yw = !t.wydg || !t.wrg[5];
    if (!t.wrg[0]) m_a = wl;
    if (!t.wrg[1]) m_l = wl;
    if (!t.wrg[3]) m_q = wl;
    if (!t.wrg[4]) m_z = wl;
    if (t.cgg) m_g = 0; else if (!t.wrg[2]) m_g = wl; else if (t.sag) m_g = t.sa;
    if (!t.wydg) m_y = {wl[14:0], wl[15]}; else if (!t.wrg[5]) m_y = wl;
    if (t.clxc) m_x = 0; else if (!t.a2xg) m_x = a_old; else if (yw) m_x = 0;
    if (t.ci) m_cir = 1; else if (yw) m_cir = 0;
  endtask

  initial begin
    vec_t r;
    logic [16:0] raw;
    logic [15:0] ms;
    //        rdg     wrg      wydg  a2xg  clxc  ci    cgg   sag   sa        wl        g         sum       co    ovf
    tbl[0]  = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00F0, 16'h0000, 16'h00F0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{RG,    WA,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00F0, 16'h00F0, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0F00, 16'h0000, 16'h0F00, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{RG,    WLG,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0F00, 16'h0F00, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{RA&RL, N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0FF0, 16'h0F00, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{RG,    WY,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 16'h0003, 16'h0003, 1'b0, 1'b0};
    tbl[7]  = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'hFFFE, 16'h0003, 1'b0, 1'b0};
    tbl[8]  = '{RG,    WA,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 16'hFFFE, 16'h0003, 1'b0, 1'b0};
    tbl[9]  = '{N,     N,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFE, E,        1'b1, 1'b0};
    tbl[10] = '{RU,    WA,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, E,        16'hFFFE, E,        1'b1, 1'b0};
    tbl[11] = '{RA,    N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, E,        16'hFFFE, E,        1'b1, 1'b0};
    tbl[12] = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'h8001, E,        1'b1, 1'b0};
    tbl[13] = '{RG,    N,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'h8001, 16'h0003, 1'b0, 1'b0};
    tbl[14] = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h8001, 16'h0004, 1'b0, 1'b0};
    tbl[15] = '{RG,    WY,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'h8001, 16'h0003, 1'b0, 1'b0};
    tbl[16] = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000, 16'h5555, 16'h0003, 1'b0, 1'b0};
    tbl[17] = '{RG,    WLG,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5555, 16'h5555, 16'h0003, 1'b0, 1'b0};
    tbl[18] = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b0};
    tbl[19] = '{RL,    WG,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h5555, 16'h5555, 16'h0003, 1'b0, 1'b0};
    tbl[20] = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b0};
    tbl[21] = '{N,     N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000, 16'h4000, 16'h0003, 1'b0, 1'b0};
    tbl[22] = '{RG,    WA&WY,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b1};
    tbl[23] = '{N,     N,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4000, 16'h8000, 1'b0, 1'b1};
    tbl[24] = '{RU,    N,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b1};

    // reset state with every read strobe low
    RDG_ = 6'h00;
    #3;
    chk("reset wl", WL, 16'h0);
    chk("reset g", G, 16'h0);
    chk("reset sum", SUM, 16'h0);
    chk("reset co", {15'b0, CO}, 16'h0);
    chk("reset ovf", {15'b0, OVF}, 16'h0);
    RDG_ = N;
    @(negedge CLOCK); rst_ = 1'b1;
    @(posedge CLOCK); #1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i]);
      @(negedge CLOCK);
      chk($sformatf("v%0d wl", i), WL, tbl[i].wl);
      @(posedge CLOCK); #1;
      chk($sformatf("v%0d g", i), G, tbl[i].g);
      chk($sformatf("v%0d sum", i), SUM, tbl[i].sum);
      chk($sformatf("v%0d co", i), {15'b0, CO}, {15'b0, tbl[i].co});
      chk($sformatf("v%0d ovf", i), {15'b0, OVF}, {15'b0, tbl[i].ovf});
    end

    // reset in the middle of a busy cycle
    r = tbl[0]; r.sag = 1'b0; r.rdg = RG; r.wrg = WQ;
    drive(r);
    @(negedge CLOCK); @(posedge CLOCK); #1;
    r.rdg = RA & RQ; r.wrg = WA & WQ & WLG; r.sag = 1'b1; r.sa = 16'hFFFF; r.a2xg = 1'b0;
    drive(r);
    #2 rst_ = 1'b0;
    #1;
    chk("rst mid wl", WL, 16'h0);
    chk("rst mid g", G, 16'h0);
    chk("rst mid sum", SUM, 16'h0);
    chk("rst mid co", {15'b0, CO}, 16'h0);
    chk("rst mid ovf", {15'b0, OVF}, 16'h0);
    @(posedge CLOCK); #1;
    chk("rst hold g", G, 16'h0);
    chk("rst hold wl", WL, 16'h0);
    @(negedge CLOCK);
    rst_ = 1'b1;
    r = tbl[11];
    drive(r);
    @(negedge CLOCK);
    chk("post rst a", WL, 16'h0);
    @(posedge CLOCK); #1;
    r.rdg = RQ;
    drive(r);
    @(negedge CLOCK);
    chk("post rst q", WL, 16'h0);
    @(posedge CLOCK); #1;

    // randomized run against the reference model
    rst_ = 1'b0;
    m_reset();
    r = tbl[11]; r.rdg = N;
    drive(r);
    @(negedge CLOCK); rst_ = 1'b1;
    @(posedge CLOCK); #1;
    for (int i = 0; i < 400; i++) begin
      r.rdg = 6'($urandom | $urandom);
      r.wrg = 6'($urandom | $urandom);
      r.wydg = $urandom_range(0, 3) != 0;
      r.a2xg = $urandom_range(0, 3) != 0;
      r.clxc = $urandom_range(0, 5) == 0;
      r.ci = $urandom_range(0, 3) == 0;
      r.cgg = $urandom_range(0, 5) == 0;
      r.sag = $urandom_range(0, 2) == 0;
      r.sa = 16'($urandom);
      drive(r);
      @(negedge CLOCK);
      chk($sformatf("rnd%0d wl", i), WL, m_wl(r.rdg));
      @(posedge CLOCK);
      m_step(r);
      #1;
      raw = m_raw();
      ms = m_sum();
      chk($sformatf("rnd%0d g", i), G, m_g);
      chk($sformatf("rnd%0d sum", i), SUM, ms);
      chk($sformatf("rnd%0d co", i), {15'b0, CO}, {15'b0, raw[16]});
      chk($sformatf("rnd%0d ovf", i), {15'b0, OVF}, {15'b0, ms[15] ^ ms[14]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
